// File: rtl/game_pkg.sv
// Shared game-logic types and timing helpers.
// Used by the hit/lives blocks and other timed game units.
package game_pkg;

    typedef enum logic [1:0] {
        ARMED        = 2'd0,
        REQUEST      = 2'd1,
        INVULNERABLE = 2'd2,
        HALTED       = 2'd3
    } state_t;

    function automatic int unsigned ms_to_cycles(
        input int unsigned freq,
        input int unsigned ms
    );
        return freq / 1000 * ms;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hit_event_controller_if.sv
// Collision/lives handshake bundle for the hit event controller.
// master = controller side, slave = game environment side.
interface hit_event_controller_if #(
    parameter int HIT_COUNT_WIDTH = 8
);
    logic                       collision;
    logic                       livesReady;
    logic                       gameOver;
    logic                       loseLife;
    logic                       invulnerable;
    logic                       blink;
    logic [HIT_COUNT_WIDTH-1:0] hitCount;

    modport master (
        input  collision, livesReady, gameOver,
        output loseLife, invulnerable, blink, hitCount
    );

    modport slave (
        output collision, livesReady, gameOver,
        input  loseLife, invulnerable, blink, hitCount
    );
endinterface

// File: rtl/hit_blink_timer.sv
// Post-hit invulnerability countdown with blink prescaler.
// blink idles visible (1); load starts a window with sprite hidden.
module hit_blink_timer
    import game_pkg::*;
#(
    parameter int unsigned INVULN_CYCLES = 10,
    parameter int unsigned BLINK_CYCLES  = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic run,
    input  logic clear,
    output logic expired,
    output logic blink
);

    localparam int IW = cnt_width(INVULN_CYCLES);
    localparam int BW = cnt_width(BLINK_CYCLES);
    localparam logic [IW-1:0] ILOAD = IW'(INVULN_CYCLES - 1);
    localparam logic [BW-1:0] BLOAD = BW'(BLINK_CYCLES - 1);

    logic [IW-1:0] icnt;
    logic [BW-1:0] bcnt;
    logic          blink_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            icnt    <= '0;
            bcnt    <= '0;
            blink_q <= 1'b1;
        end else if (load) begin
            icnt    <= ILOAD;
            bcnt    <= BLOAD;
            blink_q <= 1'b0;
        end else if (clear) begin
            icnt    <= '0;
            bcnt    <= '0;
            blink_q <= 1'b1;
        end else if (run) begin
            // window counter parks at 0 while the lives side is busy
            if (icnt != '0)
                icnt <= icnt - 1'b1;
            if (bcnt == '0) begin
                blink_q <= ~blink_q;
                bcnt    <= BLOAD;
            end else begin
                bcnt <= bcnt - 1'b1;
            end
        end
    end

    assign expired = (icnt == '0);
    assign blink   = blink_q;

endmodule

// File: rtl/hit_event_controller.sv
// Turns the level collision flag into one handshaked life-loss request
// per hit, then holds the player invulnerable (blinking) for a window.
module hit_event_controller
    import game_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ      = 50000000,
    parameter int unsigned INVULN_MS       = 2000,
    parameter int unsigned BLINK_MS        = 125,
    parameter int          HIT_COUNT_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    hit_event_controller_if.master bus
);

    localparam int unsigned INVULN_CYCLES = ms_to_cycles(CLOCK_FREQ, INVULN_MS);
    localparam int unsigned BLINK_CYCLES  = ms_to_cycles(CLOCK_FREQ, BLINK_MS);

    state_t                     state, state_n;
    logic                       lose_q, lose_n;
    logic                       inv_q, inv_n;
    logic [HIT_COUNT_WIDTH-1:0] hit_q, hit_n;
    logic                       load, run, clear;
    logic                       expired, blink;

    hit_blink_timer #(
        .INVULN_CYCLES (INVULN_CYCLES),
        .BLINK_CYCLES  (BLINK_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .run     (run),
        .clear   (clear),
        .expired (expired),
        .blink   (blink)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ARMED;
            lose_q <= 1'b0;
            inv_q  <= 1'b0;
            hit_q  <= '0;
        end else begin
            state  <= state_n;
            lose_q <= lose_n;
            inv_q  <= inv_n;
            hit_q  <= hit_n;
        end
    end

    always_comb begin
        state_n = state;
        lose_n  = lose_q;
        inv_n   = inv_q;
        hit_n   = hit_q;
        load    = 1'b0;
        run     = 1'b0;
        clear   = 1'b0;
        unique case (state)
            ARMED: begin
                lose_n = 1'b0;
                inv_n  = 1'b0;
                if (bus.gameOver) begin
                    state_n = HALTED;
                end else if (bus.collision && bus.livesReady) begin
                    state_n = REQUEST;
                    lose_n  = 1'b1;
                end
            end
            REQUEST: begin
                if (bus.gameOver) begin
                    state_n = HALTED;
                    lose_n  = 1'b0;
                end else if (!bus.livesReady) begin
                    state_n = INVULNERABLE;
                    lose_n  = 1'b0;
                    inv_n   = 1'b1;
                    load    = 1'b1;
                    if (hit_q != '1)
                        hit_n = hit_q + 1'b1;
                end
            end
            INVULNERABLE: begin
                if (bus.gameOver) begin
                    state_n = HALTED;
                    inv_n   = 1'b0;
                    clear   = 1'b1;
                end else if (expired && bus.livesReady) begin
                    state_n = ARMED;
                    inv_n   = 1'b0;
                    clear   = 1'b1;
                end else begin
                    run = 1'b1;
                end
            end
            HALTED: begin
                lose_n = 1'b0;
                inv_n  = 1'b0;
                clear  = 1'b1;
            end
            default: begin
                state_n = ARMED;
                lose_n  = 1'b0;
                inv_n   = 1'b0;
                clear   = 1'b1;
            end
        endcase
    end

    assign bus.loseLife     = lose_q;
    assign bus.invulnerable = inv_q;
    assign bus.blink        = blink;
    assign bus.hitCount     = hit_q;

endmodule

// File: tb/tb_hit_event_controller.sv
// Directed bench for hit_event_controller with short timing
// (10-cycle window, 2-cycle blink half-period).
module tb_hit_event_controller;

    localparam int W = 8;

    typedef struct {
        logic       col;
        logic       lr;
        logic       go;
        logic       lose;
        logic       inv;
        logic       blk;
        logic [7:0] hc;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    hit_event_controller_if #(.HIT_COUNT_WIDTH(W)) bus ();

    hit_event_controller #(
        .CLOCK_FREQ      (1000),
        .INVULN_MS       (10),
        .BLINK_MS        (2),
        .HIT_COUNT_WIDTH (W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   applied = 0;
    int   errors  = 0;
    bit   model_en = 1'b0;
    int   lose_age = 0;
    int   cyc = 0;
    vec_t vq[$];

    logic prev_lose, prev_inv;
    int   rises, last_rise, min_sp, inv_len, wj;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic l, input logic g,
                       input logic lo, input logic iv, input logic bk,
                       input logic [7:0] hc);
        vec_t v;
        v.col = c; v.lr = l; v.go = g;
        v.lose = lo; v.inv = iv; v.blk = bk; v.hc = hc;
        vq.push_back(v);
    endtask

    // lives updater: drops ready after seeing the request for 2 cycles
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (model_en) begin
            if (bus.loseLife) begin
                lose_age++;
                if (lose_age >= 2)
                    bus.livesReady = 1'b0;
            end else begin
                lose_age = 0;
                bus.livesReady = 1'b1;
            end
        end
    endtask

    task automatic reset_dut();
        bus.collision  = 1'b0;
        bus.gameOver   = 1'b0;
        bus.livesReady = 1'b1;
        lose_age = 0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic mon();
        if (bus.loseLife && !prev_lose) begin
            rises++;
            if (cyc - last_rise < min_sp)
                min_sp = cyc - last_rise;
            last_rise = cyc;
        end
        if (bus.invulnerable) begin
            wj      = prev_inv ? wj + 1 : 0;
            inv_len = prev_inv ? inv_len + 1 : 1;
            check("blink_in_window", bus.blink, (wj / 2) % 2);
        end else begin
            check("blink_outside", bus.blink, 1);
            if (prev_inv)
                check("window_length", inv_len, 10);
        end
        prev_lose = bus.loseLife;
        prev_inv  = bus.invulnerable;
    endtask

    initial begin
        int n, bad;
        logic p;

        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 1, 1);
        add(1, 1, 0, 0, 1, 1, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 1, 1);
        add(1, 1, 0, 0, 1, 1, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 1, 1, 1);
        add(1, 1, 0, 0, 0, 1, 1);
        add(1, 1, 1, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1, 1);

        // table: explicit inputs, lives model off
        model_en = 1'b0;
        reset_dut();
        check("reset_lose",  bus.loseLife, 0);
        check("reset_inv",   bus.invulnerable, 0);
        check("reset_blink", bus.blink, 1);
        check("reset_hits",  bus.hitCount, 0);
        foreach (vq[i]) begin
            bus.collision  = vq[i].col;
            bus.livesReady = vq[i].lr;
            bus.gameOver   = vq[i].go;
            step();
            check($sformatf("v%0d lose", i), bus.loseLife, vq[i].lose);
            check($sformatf("v%0d inv", i), bus.invulnerable, vq[i].inv);
            check($sformatf("v%0d blink", i), bus.blink, vq[i].blk);
            check($sformatf("v%0d hits", i), bus.hitCount, vq[i].hc);
        end

        // continuous collision with lives model
        model_en = 1'b1;
        reset_dut();
        for (int i = 0; i < 4; i++) step();
        bus.collision = 1'b1;
        step();
        check("request_latency", bus.loseLife, 1);
        prev_lose = 1'b1; prev_inv = 1'b0;
        rises = 1; last_rise = cyc; min_sp = 1000; inv_len = 0; wj = 0;
        for (int i = 0; i < 38; i++) begin
            step();
            mon();
        end
        bus.collision = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            mon();
        end
        check("request_count", rises, 3);
        check("request_spacing_ge13", min_sp >= 13, 1);
        check("hits_after_three", bus.hitCount, 3);

        // game over during request
        bus.collision = 1'b1;
        step();
        check("go_request_up", bus.loseLife, 1);
        bus.gameOver = 1'b1;
        step();
        check("go_lose_drop", bus.loseLife, 0);
        check("go_inv", bus.invulnerable, 0);
        check("go_blink", bus.blink, 1);
        check("go_hits_frozen", bus.hitCount, 3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.loseLife || bus.invulnerable || !bus.blink) bad++;
        end
        bus.gameOver = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.loseLife || bus.invulnerable || !bus.blink) bad++;
        end
        check("halted_quiet_cycles", bad, 0);
        check("halted_hits", bus.hitCount, 3);

        // async reset mid-request and mid-window
        reset_dut();
        bus.collision = 1'b1;
        step();
        check("rq_before_reset", bus.loseLife, 1);
        #3 reset = 1'b1;
        #1 check("async_reset_request", bus.loseLife, 0);
        #1 reset = 1'b0;
        n = 0;
        while (!bus.invulnerable && n < 20) begin
            step();
            n++;
        end
        check("window_reached", bus.invulnerable, 1);
        bus.collision = 1'b0;
        step();
        step();
        check("hits_before_reset", bus.hitCount, 1);
        #3 reset = 1'b1;
        #1;
        check("async_lose",  bus.loseLife, 0);
        check("async_inv",   bus.invulnerable, 0);
        check("async_blink", bus.blink, 1);
        check("async_hits",  bus.hitCount, 0);
        #1 reset = 1'b0;
        step();
        bus.collision = 1'b1;
        step();
        check("rearm_request", bus.loseLife, 1);

        // saturation over 300 acknowledged hits
        reset_dut();
        bus.collision = 1'b1;
        n = 0;
        p = 1'b0;
        for (int i = 0; i < 6000 && n < 300; i++) begin
            step();
            if (bus.loseLife && !p) n++;
            p = bus.loseLife;
        end
        check("hits_issued", n, 300);
        bus.collision = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("hit_saturation", bus.hitCount, 255);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
